// File: rtl/bcd_counter_n.sv
// Cascaded BCD up/down counter with DIGITS decades, in one of two modes: it
// wraps at the terminal value, or it halts there until the next load.
module bcd_counter_n #(
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic                  up,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  terminal,
  output logic                  done
);

  localparam int W = 4 * DIGITS;
  localparam bit WRAP_MODE = (WRAP != 0);

  logic [W-1:0] step_count;
  logic [W-1:0] load_sat;
  logic [W-1:0] term_value;
  logic         at_term;
  logic         next_term;

  // One full ripple step across every decade, plus a load value clamped to 0..9 per digit.
  always_comb begin
    logic       carry;
    logic [3:0] d;
    logic [3:0] ld;
    step_count = count;
    load_sat   = '0;
    carry      = 1'b1;
    d          = 4'd0;
    ld         = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      d  = count[4*k +: 4];
      ld = load_value[4*k +: 4];
      if (carry) begin
        if (up) begin
          if (d >= 4'd9) begin
            step_count[4*k +: 4] = 4'd0;
          end else begin
            step_count[4*k +: 4] = d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            step_count[4*k +: 4] = 4'd9;
          end else begin
            step_count[4*k +: 4] = d - 4'd1;
            carry = 1'b0;
          end
        end
      end
      load_sat[4*k +: 4] = (ld > 4'd9) ? 4'd9 : ld;
    end
  end

  assign term_value = up ? {DIGITS{4'h9}} : '0;
  assign at_term    = (count == term_value);
  assign next_term  = (step_count == term_value);

  // Halt mode: a step out of the terminal value is blocked rather than taken;
  // reaching the terminal value by stepping latches done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      terminal <= 1'b0;
      done     <= 1'b0;
    end else if (load) begin
      count    <= load_sat;
      terminal <= 1'b0;
      done     <= 1'b0;
    end else if (enable) begin
      if (WRAP_MODE) begin
        count    <= step_count;
        terminal <= at_term;
        done     <= 1'b0;
      end else if (done) begin
        terminal <= 1'b0;
      end else if (at_term) begin
        terminal <= 1'b1;
        done     <= 1'b1;
      end else begin
        count    <= step_count;
        terminal <= next_term;
        done     <= next_term;
      end
    end else begin
      terminal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n: three instances (2-digit wrap, 3-digit halt,
// 1-digit halt) share one clock and reset.
module tb_bcd_counter_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance a: DIGITS=2, WRAP=1
  logic       a_en = 0, a_ld = 0, a_up = 1;
  logic [7:0] a_lv = '0, a_cnt;
  logic       a_term, a_done;
  // Instance b: DIGITS=3, WRAP=0
  logic        b_en = 0, b_ld = 0, b_up = 1;
  logic [11:0] b_lv = '0, b_cnt;
  logic        b_term, b_done;
  // Instance c: DIGITS=1, WRAP=0
  logic       c_en = 0, c_ld = 0, c_up = 1;
  logic [3:0] c_lv = '0, c_cnt;
  logic       c_term, c_done;

  bcd_counter_n #(.DIGITS(2), .WRAP(1)) u_a (
    .clock(clk), .reset(rst_n), .enable(a_en), .load(a_ld), .up(a_up),
    .load_value(a_lv), .count(a_cnt), .terminal(a_term), .done(a_done));
  bcd_counter_n #(.DIGITS(3), .WRAP(0)) u_b (
    .clock(clk), .reset(rst_n), .enable(b_en), .load(b_ld), .up(b_up),
    .load_value(b_lv), .count(b_cnt), .terminal(b_term), .done(b_done));
  bcd_counter_n #(.DIGITS(1), .WRAP(0)) u_c (
    .clock(clk), .reset(rst_n), .enable(c_en), .load(c_ld), .up(c_up),
    .load_value(c_lv), .count(c_cnt), .terminal(c_term), .done(c_done));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [7:0] c, input logic t, input logic d);
    check({tag, ".count"}, 32'(a_cnt), 32'(c));
    check({tag, ".terminal"}, 32'(a_term), 32'(t));
    check({tag, ".done"}, 32'(a_done), 32'(d));
  endtask

  task automatic check_b(input string tag, input logic [11:0] c, input logic t, input logic d);
    check({tag, ".count"}, 32'(b_cnt), 32'(c));
    check({tag, ".terminal"}, 32'(b_term), 32'(t));
    check({tag, ".done"}, 32'(b_done), 32'(d));
  endtask

  task automatic check_c(input string tag, input logic [3:0] c, input logic t, input logic d);
    check({tag, ".count"}, 32'(c_cnt), 32'(c));
    check({tag, ".terminal"}, 32'(c_term), 32'(t));
    check({tag, ".done"}, 32'(c_done), 32'(d));
  endtask

  logic [7:0] down_seq [11] = '{8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04,
                                8'h03, 8'h02, 8'h01, 8'h00, 8'h99};

  initial begin
    // Reset state, checked with no clock edge having been seen under reset release.
    #2;
    check_a("rst_a", 8'h00, 1'b0, 1'b0);
    check_b("rst_b", 12'h000, 1'b0, 1'b0);
    check_c("rst_c", 4'h0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;

    // Wrap down through 00 -> 99
    a_ld = 1; a_lv = 8'h10; tick();
    check_a("a_load10", 8'h10, 1'b0, 1'b0);
    a_ld = 0; a_en = 1; a_up = 0;
    for (int i = 0; i < 11; i++) begin
      tick();
      check_a($sformatf("a_down%0d", i), down_seq[i], (i == 10), 1'b0);
    end
    a_en = 0; tick();
    check_a("a_hold", 8'h99, 1'b0, 1'b0);

    // Wrap up through 99 -> 00
    a_ld = 1; a_lv = 8'h98; a_up = 1; tick();
    a_ld = 0; a_en = 1;
    tick(); check_a("a_up99", 8'h99, 1'b0, 1'b0);
    tick(); check_a("a_up00", 8'h00, 1'b1, 1'b0);
    tick(); check_a("a_up01", 8'h01, 1'b0, 1'b0);
    a_en = 0;

    // Load saturation and load-over-enable priority
    a_ld = 1; a_lv = 8'hAF; tick();
    check_a("a_sat", 8'h99, 1'b0, 1'b0);
    a_lv = 8'h42; tick();
    check_a("a_load42", 8'h42, 1'b0, 1'b0);
    a_en = 1; a_lv = 8'h17; tick();
    check_a("a_load_en", 8'h17, 1'b0, 1'b0);
    a_ld = 0; a_en = 0;

    // Asynchronous reset mid-count
    a_ld = 1; a_lv = 8'h56; tick();
    a_ld = 0; a_en = 1; a_up = 1; tick();
    check_a("a_57", 8'h57, 1'b0, 1'b0);
    #3 rst_n = 0; #1;
    check_a("a_async_rst", 8'h00, 1'b0, 1'b0);
    tick();
    check_a("a_rst_held", 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1;
    tick();
    check_a("a_after_rst_up", 8'h01, 1'b0, 1'b0);
    #3 rst_n = 0; #1;
    check_a("a_rst2", 8'h00, 1'b0, 1'b0);
    a_up = 0;
    #1 rst_n = 1;
    tick();
    check_a("a_after_rst_dn", 8'h99, 1'b1, 1'b0);
    a_en = 0; tick();
    check_a("a_pulse_end", 8'h99, 1'b0, 1'b0);

    // Halt mode, 3 digits, counting down to 000
    b_ld = 1; b_lv = 12'hC5A; tick();
    check_b("b_sat", 12'h959, 1'b0, 1'b0);
    b_lv = 12'h002; tick();
    b_ld = 0; b_en = 1; b_up = 0;
    tick(); check_b("b_001", 12'h001, 1'b0, 1'b0);
    tick(); check_b("b_000", 12'h000, 1'b1, 1'b1);
    tick(); check_b("b_hold1", 12'h000, 1'b0, 1'b1);
    tick(); check_b("b_hold2", 12'h000, 1'b0, 1'b1);
    tick(); check_b("b_hold3", 12'h000, 1'b0, 1'b1);
    b_up = 1; tick();
    check_b("b_dirflip", 12'h000, 1'b0, 1'b1);
    b_en = 0; b_ld = 1; b_lv = 12'h998; tick();
    check_b("b_load998", 12'h998, 1'b0, 1'b0);
    b_ld = 0; b_en = 1;
    tick(); check_b("b_999", 12'h999, 1'b1, 1'b1);
    tick(); check_b("b_999h", 12'h999, 1'b0, 1'b1);
    b_en = 0; b_ld = 1; b_lv = 12'h999; tick();
    check_b("b_loadterm", 12'h999, 1'b0, 1'b0);
    b_ld = 0; b_en = 1; tick();
    check_b("b_blocked", 12'h999, 1'b1, 1'b1);
    b_en = 0;

    // Halt mode, single digit
    c_ld = 1; c_lv = 4'h9; c_up = 1; tick();
    check_c("c_load9", 4'h9, 1'b0, 1'b0);
    c_ld = 0; c_en = 1; tick();
    check_c("c_blocked", 4'h9, 1'b1, 1'b1);
    tick();
    check_c("c_held", 4'h9, 1'b0, 1'b1);
    c_up = 0; tick();
    check_c("c_down_halted", 4'h9, 1'b0, 1'b1);
    c_en = 0; c_ld = 1; c_lv = 4'h5; tick();
    check_c("c_load5", 4'h5, 1'b0, 1'b0);
    c_ld = 0; c_en = 1; tick();
    check_c("c_step4", 4'h4, 1'b0, 1'b0);
    c_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 Parameter DIGITS, default 2: number of cascaded BCD decades, legal range 1..8.
REQ-002 Parameter WRAP, default 1: 1 selects wrap-around mode, 0 selects halt-at-terminal mode.
REQ-003 Port clock  input  1  single clock; all state changes on its rising edge except reset.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port enable  input  1  count-step request, sampled each rising edge.
REQ-006 Port load  input  1  synchronous parallel-load request.
REQ-007 Port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 Port load_value  input  4*DIGITS  BCD value to load; digit k occupies bits [4k+3:4k], digit 0 least significant.
REQ-009 Port count  output  4*DIGITS  registered BCD count, same digit layout.
REQ-010 Port terminal  output  1  registered one-cycle terminal-count pulse.
REQ-011 Port done  output  1  registered sticky halt flag, used only in WRAP=0 mode.

Function
REQ-012 Each digit of count SHALL hold only values 0..9 at all times.
REQ-013 Per-edge priority SHALL be load first, then enable, then hold.
REQ-014 On load=1, count SHALL take load_value at the next edge; any load_value digit greater than 9 SHALL load as 9; done SHALL clear; terminal SHALL be 0.
REQ-015 With enable=0 and load=0, count, done and terminal-source state SHALL hold; terminal SHALL be 0.
REQ-016 With enable=1, load=0 and up=1, digit 0 SHALL increment; a digit at 9 SHALL go to 0 and carry +1 into the next digit in the same edge.
REQ-017 With enable=1, load=0 and up=0, digit 0 SHALL decrement; a digit at 0 SHALL go to 9 and borrow 1 from the next digit in the same edge.
REQ-018 The full DIGITS-wide step SHALL complete in one clock; count latency from enable sample is one edge.
REQ-019 Terminal value SHALL be all digits 0 when counting down and all digits 9 when counting up.
REQ-020 In WRAP=1, stepping down from all-0 SHALL yield all-9, and stepping up from all-9 SHALL yield all-0.
REQ-021 In WRAP=1, terminal SHALL be 1 for exactly the one cycle following each wrapping edge; done SHALL stay 0.
REQ-022 In WRAP=0, the edge at which count becomes the terminal value for the current direction SHALL set done=1 and pulse terminal for one cycle.
REQ-023 In WRAP=0 with done=1, enable SHALL be ignored and count SHALL hold until load or reset.
REQ-024 In WRAP=0, loading the terminal value SHALL not set done and SHALL not pulse terminal; the next enabled step in that direction SHALL be blocked at the boundary, leaving count unchanged, setting done and pulsing terminal.
REQ-025 A change of up SHALL take effect on the next enabled edge with no extra latency.
REQ-026 In WRAP=0, if up changes while done=1, the block SHALL stay halted until load.
REQ-027 Simultaneous load and enable SHALL perform the load only, with no step and no terminal pulse.

Reset
REQ-028 reset=0 SHALL immediately, without a clock, force count to all-0, done=0 and terminal=0.
REQ-029 Reset asserted mid-count or mid-pulse SHALL abort the operation; the first step SHALL occur at the first rising edge with reset=1.
REQ-030 While reset=0, clock, load and enable SHALL have no effect.

Verification
REQ-031 DIGITS=2, WRAP=1, load 0x10, up=0, enable 11 cycles -> count 09,08,...,00,99; terminal high only in the cycle after the 00->99 edge.
REQ-032 DIGITS=2, WRAP=1, load 0x98, up=1, enable 3 cycles -> count 99,00,01; a single terminal pulse after the 99->00 edge.
REQ-033 DIGITS=3, WRAP=0, load 0x002, up=0, enable 5 cycles -> count 001,000 then holds 000; done=1 from the edge reaching 000; one terminal pulse.
REQ-034 load_value 0xAF (DIGITS=2) -> count 99; load and enable together at count 42 with load_value 0x17 -> count 17, no step.
REQ-035 Counting at 57, reset driven low between edges -> count 00 and done 0 immediately; after release, the first enabled edge gives 01 (up) or 99 (down, WRAP=1).
REQ-036 DIGITS=1, WRAP=0, load 9, up=1, enable -> count stays 9, done=1, one terminal pulse; up=0 with enable -> still halted; load 5 -> done=0.
